// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file with retired-write counter.
// Build option: define WB_BYPASS_EN for same-cycle write-through on both read ports.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reg_write_in,
    input  logic [1:0]        s_data_write_in,
    input  logic [ADDR_W-1:0] num_write_in,
    input  logic [DATA_W-1:0] pc_4_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] mem_in,
    input  logic [ADDR_W-1:0] rs_num,
    input  logic [ADDR_W-1:0] rt_num,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_num,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  retire_count
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  retire_count_q;
    logic [CNT_W-1:0]  retire_count_d;

    // Reserved select 2'b11 falls back to the ALU result.
    always_comb begin
        wb_data = alu_in;
        case (s_data_write_in)
            2'b01:   wb_data = mem_in;
            2'b10:   wb_data = pc_4_in;
            default: wb_data = alu_in;
        endcase
    end

    assign wb_en  = reg_write_in && (num_write_in != '0);
    assign wb_num = num_write_in;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[num_write_in] <= wb_data;
        end
    end

    always_comb begin
        retire_count_d = retire_count_q;
        if (wb_en) begin
            retire_count_d = retire_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_d;
        end
    end

    assign retire_count = retire_count_q;

`ifdef WB_BYPASS_EN
    // Write-through is suppressed while reset holds so reads stay zero.
    logic bypass_ok;
    assign bypass_ok = wb_en && reset;

    always_comb begin
        rs_data = (rs_num == '0) ? '0 : regs_q[rs_num];
        rt_data = (rt_num == '0) ? '0 : regs_q[rt_num];
        if (bypass_ok && (rs_num == num_write_in)) begin
            rs_data = wb_data;
        end
        if (bypass_ok && (rt_num == num_write_in)) begin
            rt_data = wb_data;
        end
    end
`else
    always_comb begin
        rs_data = (rs_num == '0) ? '0 : regs_q[rs_num];
        rt_data = (rt_num == '0) ? '0 : regs_q[rt_num];
    end
`endif

endmodule
